// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the register-file command-port arbiter.
//   NREQ : number of requesters (fixed at 2)
//   AW   : register address width
//   DW   : register data width
//   tag_t: in-flight read tag {valid, requester id}
package reg_port_arbiter_pkg;

    localparam int unsigned NREQ = 2;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    typedef struct packed {
        logic v;
        logic id;
    } tag_t;

endpackage

// File: rtl/reg_port_arbiter_rr_arb2.sv
// Combinational 2-way round-robin arbiter with ownership lock.
//   i_req    : request per requester
//   i_lock   : requester wants to keep ownership after this grant
//   i_prio   : requester favoured when both request while unlocked
//   i_locked : a lock is active
//   i_owner  : current lock owner
//   o_gnt    : one-hot grant (zero when nothing is granted)
//   o_winner : index of the granted requester (meaningful only when o_gnt != 0)
//   o_hold   : the granted requester is asking to keep the lock
module reg_port_arbiter_rr_arb2 (
    input  logic [1:0] i_req,
    input  logic [1:0] i_lock,
    input  logic       i_prio,
    input  logic       i_locked,
    input  logic       i_owner,
    output logic [1:0] o_gnt,
    output logic       o_winner,
    output logic       o_hold
);

    logic w_win;
    logic w_valid;

    always_comb begin
        w_win   = 1'b0;
        w_valid = 1'b0;
        if (i_locked) begin
            // Only the owner may win; the other request is ignored.
            w_win   = i_owner;
            w_valid = i_req[i_owner];
        end else begin
            w_valid = |i_req;
            case (i_req)
                2'b10:   w_win = 1'b1;
                2'b11:   w_win = i_prio;
                default: w_win = 1'b0;
            endcase
        end
    end

    assign o_winner = w_win;
    assign o_gnt    = w_valid ? (w_win ? 2'b10 : 2'b01) : 2'b00;
    assign o_hold   = w_valid & i_lock[w_win];

endmodule

// File: rtl/reg_port_arbiter.sv
// Two-requester arbiter/sequencer for the register-file command port.
// Grants one command per cycle, registers it onto the rf_* port, and tags it
// so the read data returned two cycles later is flagged to its requester.
//   i_clk, i_rst            : clock, asynchronous active-high reset
//   i_req/i_lock/i_we       : per-requester request, lock, write enable
//   i_rs*/i_rt*/i_rd*       : per-requester read A / read B / write addresses
//   i_wdata*                : per-requester write data
//   o_gnt                   : one-hot grant, same cycle as the request
//   o_rvalid                : read data valid for that requester
//   o_rdata_a/o_rdata_b     : shared read data (pass-through of i_rf_a/i_rf_b)
//   o_rf_*                  : registered register-file command port
//   i_rf_a/i_rf_b           : register-file registered read outputs
module reg_port_arbiter
    import reg_port_arbiter_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [NREQ-1:0] i_req,
    input  logic [NREQ-1:0] i_lock,
    input  logic [NREQ-1:0] i_we,
    input  logic [AW-1:0]   i_rs0,
    input  logic [AW-1:0]   i_rs1,
    input  logic [AW-1:0]   i_rt0,
    input  logic [AW-1:0]   i_rt1,
    input  logic [AW-1:0]   i_rd0,
    input  logic [AW-1:0]   i_rd1,
    input  logic [DW-1:0]   i_wdata0,
    input  logic [DW-1:0]   i_wdata1,
    output logic [NREQ-1:0] o_gnt,
    output logic [NREQ-1:0] o_rvalid,
    output logic [DW-1:0]   o_rdata_a,
    output logic [DW-1:0]   o_rdata_b,
    output logic            o_rf_reg_write,
    output logic [AW-1:0]   o_rf_rs,
    output logic [AW-1:0]   o_rf_rt,
    output logic [AW-1:0]   o_rf_rd,
    output logic [DW-1:0]   o_rf_write_data,
    input  logic [DW-1:0]   i_rf_a,
    input  logic [DW-1:0]   i_rf_b
);

    logic          r_prio;
    logic          r_locked;
    logic          r_owner;
    tag_t          r_tag1;
    tag_t          r_tag2;
    logic          r_rf_reg_write;
    logic [AW-1:0] r_rf_rs;
    logic [AW-1:0] r_rf_rt;
    logic [AW-1:0] r_rf_rd;
    logic [DW-1:0] r_rf_write_data;

    logic [1:0] w_gnt;
    logic       w_winner;
    logic       w_hold;
    logic       w_gnt_any;
    logic       w_prio_d;
    logic       w_locked_d;
    logic       w_owner_d;

    reg_port_arbiter_rr_arb2 u_arb (
        .i_req    (i_req),
        .i_lock   (i_lock),
        .i_prio   (r_prio),
        .i_locked (r_locked),
        .i_owner  (r_owner),
        .o_gnt    (w_gnt),
        .o_winner (w_winner),
        .o_hold   (w_hold)
    );

    assign w_gnt_any = |w_gnt;

    always_comb begin
        w_prio_d   = r_prio;
        w_locked_d = r_locked;
        w_owner_d  = r_owner;
        if (r_locked) begin
            // Release when the owner stops requesting or takes a grant
            // without lock; the non-owner then has priority.
            if (!i_req[r_owner] || (w_gnt_any && !w_hold)) begin
                w_locked_d = 1'b0;
                w_prio_d   = ~r_owner;
            end
        end else if (w_gnt_any) begin
            w_prio_d = ~w_winner;
            if (w_hold) begin
                w_locked_d = 1'b1;
                w_owner_d  = w_winner;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prio          <= 1'b0;
            r_locked        <= 1'b0;
            r_owner         <= 1'b0;
            r_tag1          <= '0;
            r_tag2          <= '0;
            r_rf_reg_write  <= 1'b0;
            r_rf_rs         <= '0;
            r_rf_rt         <= '0;
            r_rf_rd         <= '0;
            r_rf_write_data <= '0;
        end else begin
            r_prio         <= w_prio_d;
            r_locked       <= w_locked_d;
            r_owner        <= w_owner_d;
            r_rf_reg_write <= w_gnt_any & i_we[w_winner];
            if (w_gnt_any) begin
                r_rf_rs         <= w_winner ? i_rs1 : i_rs0;
                r_rf_rt         <= w_winner ? i_rt1 : i_rt0;
                r_rf_rd         <= w_winner ? i_rd1 : i_rd0;
                r_rf_write_data <= w_winner ? i_wdata1 : i_wdata0;
            end
            r_tag1 <= '{v: w_gnt_any, id: w_winner};
            r_tag2 <= r_tag1;
        end
    end

    // Grant is combinational; hold it low while reset is asserted.
    assign o_gnt           = i_rst ? 2'b00 : w_gnt;
    assign o_rvalid        = r_tag2.v ? (r_tag2.id ? 2'b10 : 2'b01) : 2'b00;
    assign o_rdata_a       = i_rf_a;
    assign o_rdata_b       = i_rf_b;
    assign o_rf_reg_write  = r_rf_reg_write;
    assign o_rf_rs         = r_rf_rs;
    assign o_rf_rt         = r_rf_rt;
    assign o_rf_rd         = r_rf_rd;
    assign o_rf_write_data = r_rf_write_data;

endmodule

// File: tb/tb_reg_port_arbiter.sv
module tb_reg_port_arbiter;

    localparam logic [31:0] R0 = 32'h002300AA;
    localparam logic [31:0] R1 = 32'h10654321;
    localparam logic [31:0] R2 = 32'h00100022;
    localparam logic [31:0] R3 = 32'h33333333;
    localparam logic [31:0] R4 = 32'h44444444;
    localparam logic [31:0] R5 = 32'h55555555;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req, lock, we;
    logic [4:0]  rs0, rs1, rt0, rt1, rd0, rd1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt, rvalid;
    logic [31:0] rdata_a, rdata_b;
    logic        rf_reg_write;
    logic [4:0]  rf_rs, rf_rt, rf_rd;
    logic [31:0] rf_write_data;
    logic [31:0] rf_a, rf_b;
    logic [31:0] mem [32];

    int n_checks = 0;
    int n_err    = 0;

    reg_port_arbiter dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_req           (req),
        .i_lock          (lock),
        .i_we            (we),
        .i_rs0           (rs0),
        .i_rs1           (rs1),
        .i_rt0           (rt0),
        .i_rt1           (rt1),
        .i_rd0           (rd0),
        .i_rd1           (rd1),
        .i_wdata0        (wdata0),
        .i_wdata1        (wdata1),
        .o_gnt           (gnt),
        .o_rvalid        (rvalid),
        .o_rdata_a       (rdata_a),
        .o_rdata_b       (rdata_b),
        .o_rf_reg_write  (rf_reg_write),
        .o_rf_rs         (rf_rs),
        .o_rf_rt         (rf_rt),
        .o_rf_rd         (rf_rd),
        .o_rf_write_data (rf_write_data),
        .i_rf_a          (rf_a),
        .i_rf_b          (rf_b)
    );

    always #5 clk = ~clk;

    // Register file model: R0 ignores writes, reads are registered and
    // return the pre-write value when read and write hit the same edge.
    always @(posedge clk) begin
        if (rf_reg_write && rf_rd != 5'd0) mem[rf_rd] <= rf_write_data;
        rf_a <= mem[rf_rs];
        rf_b <= mem[rf_rt];
    end

    typedef struct {
        logic [1:0]  req, we;
        logic [4:0]  rs0, rt0, rd0;
        logic [31:0] wd0;
        logic [4:0]  rs1, rt1, rd1;
        logic [31:0] wd1;
        logic [1:0]  eg, ev;
        logic        ewe;
        logic [4:0]  erd;
        logic [31:0] ewd, ea, eb;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] w,
                                input int a0, input int b0, input int d0, input logic [31:0] x0,
                                input int a1, input int b1, input int d1, input logic [31:0] x1,
                                input logic [1:0] eg, input logic [1:0] ev, input logic ewe,
                                input int erd, input logic [31:0] ewd,
                                input logic [31:0] ea, input logic [31:0] eb);
        vec_t v;
        v.req = rq;        v.we = w;
        v.rs0 = 5'(a0);    v.rt0 = 5'(b0);  v.rd0 = 5'(d0);  v.wd0 = x0;
        v.rs1 = 5'(a1);    v.rt1 = 5'(b1);  v.rd1 = 5'(d1);  v.wd1 = x1;
        v.eg  = eg;        v.ev  = ev;      v.ewe = ewe;
        v.erd = 5'(erd);   v.ewd = ewd;     v.ea  = ea;      v.eb  = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        req = 2'b00; lock = 2'b00; we = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic step(input string nm, input logic [1:0] rq, input logic [1:0] lk,
                        input logic [1:0] eg, input logic [1:0] ev);
        req = rq; lock = lk;
        @(negedge clk);
        chk({nm, " gnt"}, 32'(gnt), 32'(eg));
        chk({nm, " rvalid"}, 32'(rvalid), 32'(ev));
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = R0; mem[1] = R1; mem[2] = R2; mem[3] = R3; mem[4] = R4; mem[5] = R5;
        rf_a = 32'h0; rf_b = 32'h0;
        req = 2'b11; lock = 2'b00; we = 2'b11;
        rs0 = 5'd1; rt0 = 5'd2; rd0 = 5'd3; wdata0 = 32'h1;
        rs1 = 5'd3; rt1 = 5'd4; rd1 = 5'd4; wdata1 = 32'h2;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("reset gnt", 32'(gnt), 32'h0);
        chk("reset rvalid", 32'(rvalid), 32'h0);
        chk("reset rf_reg_write", 32'(rf_reg_write), 32'h0);
        chk("reset rf_rs", 32'(rf_rs), 32'h0);
        chk("reset rf_rd", 32'(rf_rd), 32'h0);
        chk("reset rf_write_data", rf_write_data, 32'h0);
        do_reset();

        // Alternation, single read, write-then-read, R0 write
        vec[0]  = mk(2'b11, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        vec[1]  = mk(2'b11, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b10, 2'b00, 0, 0, 0, 0, 0);
        vec[2]  = mk(2'b11, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b01, 2'b01, 0, 0, 0, R1, R2);
        vec[3]  = mk(2'b11, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b10, 2'b10, 0, 0, 0, R3, R4);
        vec[4]  = mk(2'b00, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b00, 2'b01, 0, 0, 0, R1, R2);
        vec[5]  = mk(2'b00, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b00, 2'b10, 0, 0, 0, R3, R4);
        vec[6]  = mk(2'b01, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b01, 2'b00, 0, 0, 0, 0, 0);
        vec[7]  = mk(2'b00, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b00, 2'b00, 0, 0, 0, 0, 0);
        vec[8]  = mk(2'b00, 2'b00, 1, 2, 0, 32'h0, 3, 4, 0, 32'h0, 2'b00, 2'b01, 0, 0, 0, R1, R2);
        vec[9]  = mk(2'b10, 2'b10, 1, 2, 0, 32'h0, 5, 5, 5, 32'hDEADBEEF,
                     2'b10, 2'b00, 0, 0, 0, 0, 0);
        vec[10] = mk(2'b10, 2'b00, 1, 2, 0, 32'h0, 5, 0, 0, 32'h0,
                     2'b10, 2'b00, 1, 5, 32'hDEADBEEF, 0, 0);
        vec[11] = mk(2'b00, 2'b00, 1, 2, 0, 32'h0, 5, 0, 0, 32'h0, 2'b00, 2'b10, 0, 0, 0, R5, R5);
        vec[12] = mk(2'b00, 2'b00, 1, 2, 0, 32'h0, 5, 0, 0, 32'h0,
                     2'b00, 2'b10, 0, 0, 0, 32'hDEADBEEF, R0);
        vec[13] = mk(2'b01, 2'b01, 0, 0, 0, 32'hFFFFFFFF, 5, 0, 0, 32'h0,
                     2'b01, 2'b00, 0, 0, 0, 0, 0);
        vec[14] = mk(2'b01, 2'b00, 0, 1, 0, 32'h0, 5, 0, 0, 32'h0,
                     2'b01, 2'b00, 1, 0, 32'hFFFFFFFF, 0, 0);
        vec[15] = mk(2'b00, 2'b00, 0, 1, 0, 32'h0, 5, 0, 0, 32'h0, 2'b00, 2'b01, 0, 0, 0, R0, R0);
        vec[16] = mk(2'b00, 2'b00, 0, 1, 0, 32'h0, 5, 0, 0, 32'h0, 2'b00, 2'b01, 0, 0, 0, R0, R1);

        for (int k = 0; k < NV; k++) begin
            req = vec[k].req; we = vec[k].we; lock = 2'b00;
            rs0 = vec[k].rs0; rt0 = vec[k].rt0; rd0 = vec[k].rd0; wdata0 = vec[k].wd0;
            rs1 = vec[k].rs1; rt1 = vec[k].rt1; rd1 = vec[k].rd1; wdata1 = vec[k].wd1;
            @(negedge clk);
            chk($sformatf("vec%0d gnt", k), 32'(gnt), 32'(vec[k].eg));
            chk($sformatf("vec%0d rvalid", k), 32'(rvalid), 32'(vec[k].ev));
            chk($sformatf("vec%0d rf_reg_write", k), 32'(rf_reg_write), 32'(vec[k].ewe));
            if (vec[k].ewe) begin
                chk($sformatf("vec%0d rf_rd", k), 32'(rf_rd), 32'(vec[k].erd));
                chk($sformatf("vec%0d rf_write_data", k), rf_write_data, vec[k].ewd);
            end
            if (vec[k].ev != 2'b00) begin
                chk($sformatf("vec%0d rdata_a", k), rdata_a, vec[k].ea);
                chk($sformatf("vec%0d rdata_b", k), rdata_b, vec[k].eb);
            end
            @(posedge clk);
            #1;
        end

        // Lock: three grants to requester 0, then requester 1; owner drop releases
        do_reset();
        we = 2'b00;
        step("lock0", 2'b11, 2'b01, 2'b01, 2'b00);
        step("lock1", 2'b11, 2'b01, 2'b01, 2'b00);
        step("lock2", 2'b11, 2'b00, 2'b01, 2'b01);
        step("lock3", 2'b11, 2'b00, 2'b10, 2'b01);
        step("lock4", 2'b01, 2'b01, 2'b01, 2'b01);
        step("lock5", 2'b10, 2'b00, 2'b00, 2'b10);
        step("lock6", 2'b11, 2'b00, 2'b10, 2'b01);
        step("lock7", 2'b00, 2'b00, 2'b00, 2'b00);
        step("lock8", 2'b00, 2'b00, 2'b00, 2'b10);

        // Reset with two writes in flight
        do_reset();
        we = 2'b11;
        rs0 = 5'd7; rt0 = 5'd7; rd0 = 5'd7; wdata0 = 32'hAAAA0001;
        rs1 = 5'd7; rt1 = 5'd7; rd1 = 5'd7; wdata1 = 32'hBBBB0002;
        step("flight0", 2'b11, 2'b00, 2'b01, 2'b00);
        step("flight1", 2'b11, 2'b00, 2'b10, 2'b00);
        req = 2'b00; we = 2'b00;
        #1 rst = 1'b1;
        #1;
        chk("midrst rvalid", 32'(rvalid), 32'h0);
        chk("midrst rf_reg_write", 32'(rf_reg_write), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        step("postrst0", 2'b00, 2'b00, 2'b00, 2'b00);
        chk("postrst0 rf_reg_write", 32'(rf_reg_write), 32'h0);
        step("postrst1", 2'b00, 2'b00, 2'b00, 2'b00);
        chk("postrst R7", mem[7], 32'hAAAA0001);
        step("postrst2", 2'b11, 2'b00, 2'b01, 2'b00);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reg_port_arbiter.md
# reg_port_arbiter

Two-requester arbiter and sequencer for the single command port of the 32x32 register file (two registered read ports, one write port). It accepts read/write commands from two clients, e.g. decode/operand fetch and a writeback/debug path. It grants one command per cycle by round-robin with an optional lock for back-to-back sequences, and drives the register-file port from registers. It tags each issued command so that the read data returned two cycles later goes back to the originating requester.

## Interface
- `NREQ`, 2: number of requesters (fixed at 2; present for documentation and package use)
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `req[1:0]`  in  2  command request, one bit per requester
- `lock[1:0]`  in  2  keep ownership after current grant, valid with `req`
- `we[1:0]`  in  2  command includes a register write
- `rs0`, `rs1` / `rt0`, `rt1` / `rd0`, `rd1`  in  5 each  read address A / read address B / write address, per requester
- `wdata0`, `wdata1`  in  32 each  write data, per requester
- `gnt[1:0]`  out  2  one-hot grant; command accepted this cycle
- `rvalid[1:0]`  out  2  read data valid for that requester
- `rdata_a`, `rdata_b`  out  32 each  shared read data, qualified by `rvalid`
- `rf_reg_write`  out  1  register-file write enable
- `rf_rs`, `rf_rt`, `rf_rd`  out  5 each  register-file addresses
- `rf_write_data`  out  32  register-file write data
- `rf_a`, `rf_b`  in  32 each  register-file registered read outputs

## Operation
- Arbitration is combinational from `req`, the priority pointer `prio` (1 bit) and the lock owner (`locked`, `owner`).
- Unlocked: if exactly one `req` is set, that requester wins. If both are set, requester `prio` wins. On any grant, `prio` becomes the non-winner.
- Locked: only `owner` can be granted. The other requester's `req` is ignored.
- The lock is set on a grant with `lock[winner]` = 1 and `owner` = winner. It clears on a grant to `owner` with `lock[owner]` = 0, or on any cycle with `req[owner]` = 0.
- `prio` does not advance while locked. On release, the non-owner has priority.
- The granted command is captured into `rf_*` at the clock edge.
- `rf_reg_write` = `we[winner]`, and is 0 on idle cycles. Non-write commands still issue reads.
- `rd` = 0 writes are issued unchanged. The register file ignores them.
- Tag pipeline is two stages `{v, id}`: stage 1 is loaded on the grant edge, stage 2 follows from stage 1. `rvalid[id2]` = `v2`.
- `rdata_a`/`rdata_b` are direct from `rf_a`/`rf_b`.
- Same-command write and read of the same register returns the old value. A read issued one cycle after a write to that register returns the new value. No forwarding or stall logic is included.

## Timing
- Reset values: `gnt` = 0, `rvalid` = 0, `rf_reg_write` = 0, `rf_rs`/`rf_rt`/`rf_rd` = 0, `rf_write_data` = 0, `prio` = 0, `locked` = 0, tag valids = 0.
- Grant in cycle t (same cycle as `req`). `rf_*` is valid in t+1. The register file samples at the end of t+1. `rvalid`/`rdata` are valid in cycle t+2.
- Throughput is one command per cycle. Requester commands must be held stable while `req` is high and `gnt` is low.
- Simultaneous requests alternate A, B, A, B when neither locks.
- Reset asserted mid-operation clears both tag stages immediately. In-flight responses are dropped (no `rvalid`), and no write issues after reset.

## Structure
- A shared package holds `NREQ`, the address width (5), the data width (32), and the tag struct `{logic v; logic id;}`.
- One sub-module is natural: `rr_arb2`, the combinational 2-way round-robin with lock (inputs `req`, `lock`, `prio`, `locked`, `owner`; outputs `gnt`, `winner`).
- The top level holds the state registers, the `rf_*` output registers and the tag pipeline.

## Test plan
- Reset, then `req[0]` read rs=1, rt=2 with the register file preloaded R1=0x10654321, R2=0x00100022 -> `gnt[0]` at t; `rvalid[0]` at t+2 with `rdata_a`=0x10654321, `rdata_b`=0x00100022.
- Both requesting continuously, no lock -> grants 0,1,0,1. Each `rvalid` lands two cycles after its grant, on the matching bit.
- `req[1]` writes rd=5 with 0xDEADBEEF, then reads rs=5 next cycle -> second read returns 0xDEADBEEF. Same-command write+read of rd=rs=5 returns the previous R5.
- `req[0]` with lock held for 3 grants while `req[1]` is high -> `gnt[0]` for 3 cycles. After lock drops, `gnt[1]` next cycle.
- Write to rd=0 with 0xFFFFFFFF, then read rs=0 -> the original R0 value 0x002300AA is unchanged.
- `rst` pulsed while two commands are in flight -> no `rvalid` afterwards, `rf_reg_write` = 0, next simultaneous request grants requester 0.
